// File: rtl/riscv_v_uop_seq_if.sv
//------------------------------------------------------------------------------
// Module   : riscv_v_uop_seq_if
// Brief    : ID-side instruction handshake and EXE-side micro-op bus of the
//            vector register-group sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface riscv_v_uop_seq_if #(
    parameter int VLEN          = 128,
    parameter int MAX_LMUL      = 8,
    parameter int INSTR_WIDTH   = 32,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int VL_WIDTH      = $clog2(VLEN/8*MAX_LMUL)+1
);
    logic                     instr_valid_id;
    logic [INSTR_WIDTH-1:0]   instruction_id;
    logic [8:0]               vtype_id;
    logic [VL_WIDTH-1:0]      vl_id;
    logic                     instr_ready_id;
    logic                     riscv_v_stall;
    logic                     uop_valid_exe;
    logic [INSTR_WIDTH-1:0]   uop_instr_exe;
    logic [RF_ADDR_WIDTH-1:0] uop_vd_exe;
    logic [RF_ADDR_WIDTH-1:0] uop_vs1_exe;
    logic [RF_ADDR_WIDTH-1:0] uop_vs2_exe;
    logic [2:0]               uop_idx_exe;
    logic                     uop_last_exe;
    logic [VLEN/8-1:0]        uop_byte_en_exe;
    logic                     illegal_exe;

    modport master (
        output instr_valid_id, instruction_id, vtype_id, vl_id,
        input  instr_ready_id, riscv_v_stall, uop_valid_exe, uop_instr_exe,
               uop_vd_exe, uop_vs1_exe, uop_vs2_exe, uop_idx_exe,
               uop_last_exe, uop_byte_en_exe, illegal_exe
    );

    modport slave (
        input  instr_valid_id, instruction_id, vtype_id, vl_id,
        output instr_ready_id, riscv_v_stall, uop_valid_exe, uop_instr_exe,
               uop_vd_exe, uop_vs1_exe, uop_vs2_exe, uop_idx_exe,
               uop_last_exe, uop_byte_en_exe, illegal_exe
    );
endinterface

`default_nettype wire

// File: rtl/riscv_v_uop_seq.sv
//------------------------------------------------------------------------------
// Module   : riscv_v_uop_seq
// Brief    : Expands one vector instruction into LMUL single-register micro-ops
//            with per-byte write enables derived from vl and SEW.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module riscv_v_uop_seq #(
    parameter int VLEN          = 128,
    parameter int MAX_LMUL      = 8,
    parameter int INSTR_WIDTH   = 32,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int VL_WIDTH      = $clog2(VLEN/8*MAX_LMUL)+1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_pipe,
    input  logic               riscv_stall,
    riscv_v_uop_seq_if.slave   bus
);
    localparam int C_VLENB   = VLEN/8;
    localparam int C_MAX_LOG = $clog2(MAX_LMUL);
    localparam int C_POS_W   = $clog2(C_VLENB*8)+2;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;
    state_t r_state, w_state_nxt;

    logic [INSTR_WIDTH-1:0]   r_instr;
    logic [1:0]               r_sew;
    logic [VL_WIDTH-1:0]      r_vl;
    logic [2:0]               r_lmul_m1;
    logic                     r_vv;
    logic [RF_ADDR_WIDTH-1:0] r_vd, r_vs1, r_vs2;
    logic [2:0]               r_idx;
    logic                     r_last, r_ill;
    logic [C_VLENB-1:0]       r_be;

    logic                     w_in_ready, w_accept, w_advance;
    logic [2:0]               w_vlmul, w_vsew;
    logic [1:0]               w_lmul_log;
    logic [2:0]               w_lmul_m1;
    logic                     w_in_vv, w_misalign, w_illegal;
    logic [INSTR_WIDTH-1:0]   w_src_instr;
    logic [1:0]               w_src_sew;
    logic [VL_WIDTH-1:0]      w_src_vl;
    logic [2:0]               w_src_lmul_m1, w_src_k;
    logic                     w_src_vv;
    logic [RF_ADDR_WIDTH-1:0] w_k_ext, w_nxt_vd, w_nxt_vs1, w_nxt_vs2;
    logic [C_POS_W-1:0]       w_grp_end;
    logic                     w_nxt_last;
    logic [C_VLENB-1:0]       w_nxt_be;
    logic                     w_unused_vtype;

    assign w_unused_vtype = ^bus.vtype_id[8:6];

    assign w_in_ready = !clear_pipe &&
                        (r_state == S_IDLE || (r_state == S_ISSUE && r_last && !riscv_stall));
    assign w_accept   = bus.instr_valid_id && w_in_ready;
    assign w_advance  = (r_state == S_ISSUE) && !riscv_stall && !r_last;

    // Fractional LMUL (1xx) occupies a single register like LMUL=1
    assign w_vlmul    = bus.vtype_id[2:0];
    assign w_vsew     = bus.vtype_id[5:3];
    assign w_lmul_log = w_vlmul[2] ? 2'd0 : w_vlmul[1:0];
    assign w_lmul_m1  = 3'((4'd1 << w_lmul_log) - 4'd1);
    assign w_in_vv    = (bus.instruction_id[6:0] == 7'b1010111) &&
                        (bus.instruction_id[14:12] == 3'b000 || bus.instruction_id[14:12] == 3'b010);
    assign w_misalign = |(RF_ADDR_WIDTH'(bus.instruction_id[11:7])  & RF_ADDR_WIDTH'(w_lmul_m1)) ||
                        |(RF_ADDR_WIDTH'(bus.instruction_id[24:20]) & RF_ADDR_WIDTH'(w_lmul_m1)) ||
                        (w_in_vv && |(RF_ADDR_WIDTH'(bus.instruction_id[19:15]) & RF_ADDR_WIDTH'(w_lmul_m1)));
    assign w_illegal  = (w_vlmul == 3'b100) || (int'(w_lmul_log) > C_MAX_LOG) ||
                        w_vsew[2] || w_misalign;

    // Next micro-op is built from the incoming instruction on accept, else from the snapshot
    assign w_src_instr   = w_accept ? bus.instruction_id : r_instr;
    assign w_src_sew     = w_accept ? w_vsew[1:0]        : r_sew;
    assign w_src_vl      = w_accept ? bus.vl_id          : r_vl;
    assign w_src_lmul_m1 = w_accept ? w_lmul_m1          : r_lmul_m1;
    assign w_src_vv      = w_accept ? w_in_vv            : r_vv;
    assign w_src_k       = w_accept ? 3'd0               : r_idx + 3'd1;

    assign w_k_ext   = RF_ADDR_WIDTH'(w_src_k);
    assign w_nxt_vd  = RF_ADDR_WIDTH'(w_src_instr[11:7])  + w_k_ext;
    assign w_nxt_vs2 = RF_ADDR_WIDTH'(w_src_instr[24:20]) + w_k_ext;
    assign w_nxt_vs1 = w_src_vv ? RF_ADDR_WIDTH'(w_src_instr[19:15]) + w_k_ext
                                : RF_ADDR_WIDTH'(w_src_instr[19:15]);

    // Last when the group is exhausted or the following register holds no element below vl
    assign w_grp_end  = ((C_POS_W'(w_src_k) + C_POS_W'(1)) * C_POS_W'(C_VLENB)) >> w_src_sew;
    assign w_nxt_last = (w_src_k == w_src_lmul_m1) || (w_grp_end >= C_POS_W'(w_src_vl));

    always_comb begin : b_byte_en
        logic [C_POS_W-1:0] pos;
        pos      = '0;
        w_nxt_be = '0;
        for (int b = 0; b < C_VLENB; b++) begin
            pos         = C_POS_W'(w_src_k) * C_POS_W'(C_VLENB) + C_POS_W'(b);
            w_nxt_be[b] = (pos >> w_src_sew) < C_POS_W'(w_src_vl);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear_pipe)
            w_state_nxt = S_IDLE;
        else if (w_accept)
            w_state_nxt = S_ISSUE;
        else if (r_state == S_ISSUE && !riscv_stall && r_last)
            w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr   <= '0;
            r_sew     <= '0;
            r_vl      <= '0;
            r_lmul_m1 <= '0;
            r_vv      <= 1'b0;
            r_vd      <= '0;
            r_vs1     <= '0;
            r_vs2     <= '0;
            r_idx     <= '0;
            r_last    <= 1'b0;
            r_ill     <= 1'b0;
            r_be      <= '0;
        end else if (clear_pipe) begin
            r_last <= 1'b0;
            r_ill  <= 1'b0;
            r_be   <= '0;
        end else if (w_accept || w_advance) begin
            if (w_accept) begin
                r_instr   <= bus.instruction_id;
                r_sew     <= w_vsew[1:0];
                r_vl      <= bus.vl_id;
                r_lmul_m1 <= w_lmul_m1;
                r_vv      <= w_in_vv;
            end
            r_vd   <= w_nxt_vd;
            r_vs1  <= w_nxt_vs1;
            r_vs2  <= w_nxt_vs2;
            r_idx  <= w_src_k;
            r_ill  <= w_accept && w_illegal;
            r_last <= (w_accept && w_illegal) || w_nxt_last;
            r_be   <= (w_accept && w_illegal) ? '0 : w_nxt_be;
        end
    end

    assign bus.instr_ready_id  = w_in_ready;
    assign bus.riscv_v_stall   = (r_state == S_ISSUE) && !(r_last && !riscv_stall);
    assign bus.uop_valid_exe   = (r_state == S_ISSUE);
    assign bus.uop_instr_exe   = r_instr;
    assign bus.uop_vd_exe      = r_vd;
    assign bus.uop_vs1_exe     = r_vs1;
    assign bus.uop_vs2_exe     = r_vs2;
    assign bus.uop_idx_exe     = r_idx;
    assign bus.uop_last_exe    = r_last;
    assign bus.uop_byte_en_exe = r_be;
    assign bus.illegal_exe     = r_ill;
endmodule

`default_nettype wire

// File: tb/tb_riscv_v_uop_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_riscv_v_uop_seq
// Brief    : Directed and randomized bench for riscv_v_uop_seq against a
//            per-instruction micro-op expansion model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_riscv_v_uop_seq;
    localparam int VLEN     = 128;
    localparam int MAX_LMUL = 8;
    localparam int IW       = 32;
    localparam int AW       = 5;
    localparam int VLW      = $clog2(VLEN/8*MAX_LMUL)+1;
    localparam int VLENB    = VLEN/8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear_pipe = 1'b0;
    logic riscv_stall = 1'b0;

    riscv_v_uop_seq_if #(.VLEN(VLEN), .MAX_LMUL(MAX_LMUL), .INSTR_WIDTH(IW),
                         .RF_ADDR_WIDTH(AW), .VL_WIDTH(VLW)) bus ();

    riscv_v_uop_seq #(.VLEN(VLEN), .MAX_LMUL(MAX_LMUL), .INSTR_WIDTH(IW),
                      .RF_ADDR_WIDTH(AW), .VL_WIDTH(VLW)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear_pipe  (clear_pipe),
        .riscv_stall (riscv_stall),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]       vd, vs1, vs2;
        logic [2:0]       idx;
        logic             last, ill;
        logic [VLENB-1:0] be;
        logic [31:0]      instr;
    } uop_t;

    uop_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int f3, input int vd, input int vs1, input int vs2);
        return {6'b0, 1'b1, 5'(vs2), 5'(vs1), 3'(f3), 5'(vd), 7'b1010111};
    endfunction

    function automatic logic [8:0] vt(input int vsew, input int vlmul);
        return {3'b000, 3'(vsew), 3'(vlmul)};
    endfunction

    // Reference: list of micro-ops an accepted instruction must produce
    function automatic void expand(input logic [31:0] ins, input logic [8:0] vtype, input int vl);
        int   lmul, sewb, n, vd, vs1, vs2;
        bit   vv, ill;
        uop_t u;
        lmul = vtype[2] ? 1 : (1 << vtype[1:0]);
        vv   = (ins[6:0] == 7'b1010111) && (ins[14:12] == 3'd0 || ins[14:12] == 3'd2);
        vd   = int'(ins[11:7]);
        vs1  = int'(ins[19:15]);
        vs2  = int'(ins[24:20]);
        ill  = (vtype[2:0] == 3'b100) || (lmul > MAX_LMUL) || vtype[5] ||
               (vd % lmul != 0) || (vs2 % lmul != 0) || (vv && (vs1 % lmul != 0));
        u.instr = ins;
        if (ill) begin
            u.vd = '0; u.vs1 = '0; u.vs2 = '0; u.idx = '0;
            u.last = 1'b1; u.ill = 1'b1; u.be = '0;
            exp_q.push_back(u);
        end else begin
            sewb = 1 << vtype[4:3];
            n = (vl * sewb + VLENB - 1) / VLENB;
            if (n > lmul) n = lmul;
            if (n < 1)    n = 1;
            for (int k = 0; k < n; k++) begin
                u.vd   = 5'(vd + k);
                u.vs2  = 5'(vs2 + k);
                u.vs1  = vv ? 5'(vs1 + k) : 5'(vs1);
                u.idx  = 3'(k);
                u.last = (k == n - 1);
                u.ill  = 1'b0;
                for (int b = 0; b < VLENB; b++)
                    u.be[b] = ((k * VLENB + b) / sewb) < vl;
                exp_q.push_back(u);
            end
        end
    endfunction

    // One clock: drive, compare against model head, advance model
    task automatic step(input bit v, input logic [31:0] ins, input logic [8:0] vtype, input int vl,
                        input bit st, input bit clr, output bit acc);
        bit empty, one, e_ready, e_vstall;
        bus.instr_valid_id = v;
        bus.instruction_id = ins;
        bus.vtype_id       = vtype;
        bus.vl_id          = VLW'(vl);
        riscv_stall        = st;
        clear_pipe         = clr;
        #1;
        empty    = (exp_q.size() == 0);
        one      = (exp_q.size() == 1);
        e_ready  = !clr && (empty || (one && !st));
        e_vstall = !empty && !(one && !st);
        chk("instr_ready_id", 64'(bus.instr_ready_id), 64'(e_ready));
        chk("riscv_v_stall",  64'(bus.riscv_v_stall),  64'(e_vstall));
        chk("uop_valid_exe",  64'(bus.uop_valid_exe),  64'(!empty));
        if (!empty) begin
            chk("illegal_exe",     64'(bus.illegal_exe),     64'(exp_q[0].ill));
            chk("uop_last_exe",    64'(bus.uop_last_exe),    64'(exp_q[0].last));
            chk("uop_byte_en_exe", 64'(bus.uop_byte_en_exe), 64'(exp_q[0].be));
            chk("uop_instr_exe",   64'(bus.uop_instr_exe),   64'(exp_q[0].instr));
            if (!exp_q[0].ill) begin
                chk("uop_vd_exe",  64'(bus.uop_vd_exe),  64'(exp_q[0].vd));
                chk("uop_vs1_exe", 64'(bus.uop_vs1_exe), 64'(exp_q[0].vs1));
                chk("uop_vs2_exe", 64'(bus.uop_vs2_exe), 64'(exp_q[0].vs2));
                chk("uop_idx_exe", 64'(bus.uop_idx_exe), 64'(exp_q[0].idx));
            end
        end
        acc = v && e_ready;
        @(posedge clk);
        #1;
        if (clr) begin
            exp_q.delete();
        end else begin
            if (!empty && !st) void'(exp_q.pop_front());
            if (acc) expand(ins, vtype, vl);
        end
    endtask

    task automatic send(input logic [31:0] ins, input logic [8:0] vtype, input int vl);
        bit acc;
        int g;
        acc = 1'b0;
        g   = 0;
        while (!acc && g < 64) begin
            step(1'b1, ins, vtype, vl, 1'b0, 1'b0, acc);
            g++;
        end
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $error("FAIL send_timeout: observed no accept expected accept within 64 cycles");
        end
    endtask

    task automatic idle(input int n, input bit st);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 9'h0, 0, st, 1'b0, acc);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 64) begin
            idle(1, 1'b0);
            g++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL drain_timeout: observed %0d pending expected 0", exp_q.size());
        end
        idle(1, 1'b0);
    endtask

    task automatic gen(output logic [31:0] ins, output logic [8:0] vtype, output int vl);
        int vlmul, vsew, lmul, mask, f3;
        logic [6:0] op;
        vlmul = $urandom_range(0, 7);
        vsew  = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
        lmul  = (vlmul >= 4) ? 1 : (1 << vlmul);
        mask  = ($urandom_range(0, 6) == 0) ? 0 : lmul - 1;
        case ($urandom_range(0, 3))
            0:       f3 = 0;
            1:       f3 = 2;
            2:       f3 = 4;
            default: f3 = 3;
        endcase
        op    = ($urandom_range(0, 9) == 0) ? 7'b0000111 : 7'b1010111;
        ins   = {7'($urandom), 5'($urandom_range(0, 31) & ~mask), 5'($urandom_range(0, 31) & ~mask),
                 3'(f3), 5'($urandom_range(0, 31) & ~mask), op};
        vtype = {3'($urandom), 3'(vsew), 3'(vlmul)};
        vl    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : $urandom_range(0, VLENB * MAX_LMUL);
    endtask

    initial begin
        logic [31:0] ins;
        logic [8:0]  vtype;
        int          vl, gap;
        bit          acc, st, clr;

        bus.instr_valid_id = 1'b1;
        bus.instruction_id = enc(0, 8, 24, 16);
        bus.vtype_id       = vt(0, 2);
        bus.vl_id          = VLW'(64);
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_valid",   64'(bus.uop_valid_exe),   64'd0);
            chk("rst_last",    64'(bus.uop_last_exe),    64'd0);
            chk("rst_illegal", 64'(bus.illegal_exe),     64'd0);
            chk("rst_byte_en", 64'(bus.uop_byte_en_exe), 64'd0);
            chk("rst_vd",      64'(bus.uop_vd_exe),      64'd0);
            chk("rst_v_stall", 64'(bus.riscv_v_stall),   64'd0);
        end
        rst = 1'b0;

        // vadd.vv LMUL=4 SEW=8 vl=64, presented right after reset
        send(enc(0, 8, 24, 16), vt(0, 2), 64);
        drain();
        // vadd.vx LMUL=2 SEW=32 vl=5
        send(enc(4, 4, 5, 6), vt(2, 1), 5);
        drain();
        // LMUL=8 short vl and vl=0
        send(enc(0, 8, 24, 16), vt(0, 3), 3);
        drain();
        send(enc(0, 8, 24, 16), vt(0, 3), 0);
        drain();
        // Illegal: misaligned vd, reserved vlmul, reserved vsew
        send(enc(0, 3, 4, 6), vt(0, 1), 16);
        drain();
        send(enc(0, 0, 0, 0), vt(0, 4), 16);
        drain();
        send(enc(0, 0, 0, 0), vt(4, 0), 16);
        drain();
        // Fractional LMUL accepts any register
        send(enc(0, 3, 5, 7), vt(0, 7), 16);
        drain();
        // Stall held three cycles on uop1
        send(enc(0, 8, 24, 16), vt(0, 2), 64);
        idle(1, 1'b0);
        idle(3, 1'b1);
        drain();
        // Flush at uop2, new instruction the following cycle
        send(enc(0, 8, 24, 16), vt(0, 2), 64);
        idle(2, 1'b0);
        step(1'b0, 32'h0, 9'h0, 0, 1'b0, 1'b1, acc);
        send(enc(2, 16, 0, 8), vt(1, 3), 40);
        drain();
        // Back-to-back without bubble
        send(enc(0, 8, 24, 16), vt(0, 2), 64);
        send(enc(4, 2, 9, 4), vt(2, 1), 7);
        send(enc(0, 0, 8, 16), vt(3, 3), 13);
        drain();

        gen(ins, vtype, vl);
        gap = 0;
        repeat (3000) begin
            st  = ($urandom_range(0, 9) == 0);
            clr = ($urandom_range(0, 99) == 0);
            if (gap > 0) begin
                step(1'b0, ins, vtype, vl, st, clr, acc);
                gap--;
            end else begin
                step(1'b1, ins, vtype, vl, st, clr, acc);
                if (acc) begin
                    gen(ins, vtype, vl);
                    gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                end
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no completion expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
